// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream TX path between NUM_SRC sources.
// A source keeps the output from its first accepted beat until its tlast beat is accepted.
module eth_tx_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_trdy,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_trdy,
    output logic [NUM_SRC-1:0]            o_grant,
    output logic                          o_busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam logic [NUM_SRC-1:0] GRANT_ONE = {{(NUM_SRC-1){1'b0}}, 1'b1};
    localparam logic [SRC_W-1:0]   LAST_RST  = SRC_W'(NUM_SRC - 1);

    state_t                  state_r, state_nxt_s;
    logic [NUM_SRC-1:0]      grant_r, grant_nxt_s;
    logic [SRC_W-1:0]        gidx_r, gidx_nxt_s;
    logic [SRC_W-1:0]        last_src_r, last_src_nxt_s;
    logic [SRC_W:0]          pick_s;
    logic                    out_free_s;
    logic                    accept_s;
    logic [DATA_WIDTH-1:0]   m_tdata_r;
    logic                    m_tvalid_r;
    logic                    m_tlast_r;

    // Round-robin search starting one past last: returns {found, index}.
    // Scanning from the farthest candidate down lets the nearest requester win.
    function automatic logic [SRC_W:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [SRC_W-1:0]   last);
        logic [SRC_W:0]   res;
        logic [SRC_W-1:0] idx;
        res = {(SRC_W+1){1'b0}};
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = SRC_W'((int'(last) + k) % NUM_SRC);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s     = rr_pick(s_axis_tvalid, last_src_r);
    assign out_free_s = !m_tvalid_r || m_axis_trdy;
    assign accept_s   = (state_r == ST_XFER) && s_axis_tvalid[gidx_r] && out_free_s;

    // Ready goes only to the locked source, and only when the output stage can take a beat.
    always_comb begin
        s_axis_trdy = {NUM_SRC{1'b0}};
        if (state_r == ST_XFER) begin
            s_axis_trdy = grant_r & {NUM_SRC{out_free_s}};
        end else begin
            s_axis_trdy = {NUM_SRC{1'b0}};
        end
    end

    // Next-state logic: grant in IDLE, release only on an accepted tlast beat.
    always_comb begin
        state_nxt_s    = state_r;
        grant_nxt_s    = grant_r;
        gidx_nxt_s     = gidx_r;
        last_src_nxt_s = last_src_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[SRC_W]) begin
                    state_nxt_s    = ST_XFER;
                    grant_nxt_s    = GRANT_ONE << pick_s[SRC_W-1:0];
                    gidx_nxt_s     = pick_s[SRC_W-1:0];
                    last_src_nxt_s = pick_s[SRC_W-1:0];
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = {NUM_SRC{1'b0}};
                end
            end
            ST_XFER: begin
                if (accept_s && s_axis_tlast[gidx_r]) begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = {NUM_SRC{1'b0}};
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = {NUM_SRC{1'b0}};
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= ST_IDLE;
            grant_r    <= {NUM_SRC{1'b0}};
            gidx_r     <= {SRC_W{1'b0}};
            last_src_r <= LAST_RST;
        end else begin
            state_r    <= state_nxt_s;
            grant_r    <= grant_nxt_s;
            gidx_r     <= gidx_nxt_s;
            last_src_r <= last_src_nxt_s;
        end
    end

    // Output stage: load on accept, drain when downstream takes the beat, otherwise hold.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_tdata_r  <= {DATA_WIDTH{1'b0}};
            m_tlast_r  <= 1'b0;
            m_tvalid_r <= 1'b0;
        end else if (accept_s) begin
            m_tdata_r  <= s_axis_tdata[gidx_r*DATA_WIDTH +: DATA_WIDTH];
            m_tlast_r  <= s_axis_tlast[gidx_r];
            m_tvalid_r <= 1'b1;
        end else if (m_axis_trdy) begin
            m_tvalid_r <= 1'b0;
        end
    end

    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tlast  = m_tlast_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign o_grant       = grant_r;
    assign o_busy        = (state_r == ST_XFER);

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter with three sources: per-source frame queues drive the
// inputs, expected beats are queued in the order arbitration should emit them.
module tb_eth_tx_arbiter;

    localparam int NS = 3;
    localparam int DW = 8;

    logic             i_clk;
    logic             i_reset_n;
    logic [NS*DW-1:0] s_axis_tdata;
    logic [NS-1:0]    s_axis_tvalid;
    logic [NS-1:0]    s_axis_tlast;
    logic [NS-1:0]    s_axis_trdy;
    logic [DW-1:0]    m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_trdy;
    logic [NS-1:0]    o_grant;
    logic             o_busy;

    eth_tx_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_trdy  (s_axis_trdy),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_trdy  (m_axis_trdy),
        .o_grant      (o_grant),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] sq [NS][$];
    logic [8:0] exp_q [$];
    logic       mtrdy_pat [$];
    logic       cur_mtrdy = 1'b1;
    int         pause [NS];
    logic       hold_v = 1'b0;
    logic [8:0] hold_d = 9'd0;
    logic       gap_chk = 1'b0;
    logic       after_last = 1'b0;
    int         gap = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic q_src(input int src, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) sq[src].push_back({(k == n - 1), 8'(base + k)});
    endtask

    task automatic q_exp(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({(k == n - 1), 8'(base + k)});
    endtask

    task automatic next_mtrdy();
        if (mtrdy_pat.size() > 0) cur_mtrdy = mtrdy_pat.pop_front();
        else cur_mtrdy = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (pause[i] == 0 && sq[i].size() > 0) begin
                s_axis_tvalid[i]       = 1'b1;
                s_axis_tlast[i]        = sq[i][0][8];
                s_axis_tdata[i*DW +: DW] = sq[i][0][7:0];
            end else begin
                s_axis_tvalid[i]       = 1'b0;
                s_axis_tlast[i]        = 1'($urandom);
                s_axis_tdata[i*DW +: DW] = 8'($urandom);
            end
        end
        m_axis_trdy = cur_mtrdy;
    endtask

    // One clock: sample just before the edge, score, advance sources, redrive at negedge.
    task automatic tick();
        logic [NS-1:0] acc;
        logic          m_hs;
        logic [8:0]    e;
        logic [8:0]    dummy;
        #4;
        acc  = s_axis_tvalid & s_axis_trdy;
        m_hs = m_axis_tvalid & m_axis_trdy;
        if (o_busy) check_val("s_trdy", s_axis_trdy, o_grant & {NS{(!m_axis_tvalid) || m_axis_trdy}});
        else        check_val("s_trdy_idle", s_axis_trdy, 3'b000);
        if (hold_v) begin
            check_val("hold_valid", m_axis_tvalid, 1'b1);
            check_val("hold_data", {m_axis_tlast, m_axis_tdata}, hold_d);
        end
        hold_v = m_axis_tvalid && !m_axis_trdy;
        hold_d = {m_axis_tlast, m_axis_tdata};
        if (m_hs) begin
            if (exp_q.size() == 0) begin
                check_val("extra_beat", {m_axis_tlast, m_axis_tdata}, 9'h1ff);
            end else begin
                e = exp_q.pop_front();
                check_val("beat", {m_axis_tlast, m_axis_tdata}, e);
            end
            if (gap_chk && after_last) check_val("bubble", gap, 1);
            after_last = m_axis_tlast;
            gap = 0;
        end else if (!m_axis_tvalid) begin
            gap++;
        end
        @(posedge i_clk);
        for (int i = 0; i < NS; i++) begin
            if (acc[i] && sq[i].size() > 0) dummy = sq[i].pop_front();
            if (pause[i] > 0) pause[i]--;
        end
        next_mtrdy();
        @(negedge i_clk);
        drive();
    endtask

    task automatic run_until_done(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < max_cyc) begin
            tick();
            n++;
        end
        if (n >= max_cyc) check_val("timeout_left", exp_q.size(), 0);
        check_val("src_drained", sq[0].size() + sq[1].size() + sq[2].size(), 0);
        check_val("idle_grant", o_grant, 3'b000);
    endtask

    task automatic tick_until_src(input int src, input int left, input int max_cyc);
        int n;
        n = 0;
        while (sq[src].size() > left && n < max_cyc) begin
            tick();
            n++;
        end
        if (n >= max_cyc) check_val("wait_timeout", sq[src].size(), left);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) pause[i] = 0;
        i_reset_n     = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_trdy   = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        check_val("rst_grant", o_grant, 3'b000);
        check_val("rst_busy", o_busy, 1'b0);
        check_val("rst_s_trdy", s_axis_trdy, 3'b000);
        check_val("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check_val("rst_m_tlast", m_axis_tlast, 1'b0);
        check_val("rst_m_tdata", m_axis_tdata, 8'h00);
        i_reset_n = 1'b1;
        drive();

        // Single source 4-beat frame and arbitration/data latency.
        q_src(0, 8'h11, 4); q_exp(8'h11, 4); drive();
        tick();
        check_val("lat_grant", o_grant, 3'b001);
        check_val("lat_busy", o_busy, 1'b1);
        check_val("lat_no_out_yet", m_axis_tvalid, 1'b0);
        tick();
        check_val("lat_first_valid", m_axis_tvalid, 1'b1);
        check_val("lat_first_data", m_axis_tdata, 8'h11);
        check_val("frame_grant", o_grant, 3'b001);
        run_until_done(50);

        // Mid-frame stall: granted src1 pauses while src0 waits.
        q_src(1, 8'h41, 5); q_exp(8'h41, 5); drive();
        tick_until_src(1, 3, 20);
        q_src(0, 8'h51, 3); q_exp(8'h51, 3);
        pause[1] = 3;
        drive();
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("stall_grant", o_grant, 3'b010);
            check_val("stall_trdy0", s_axis_trdy[0], 1'b0);
        end
        run_until_done(60);

        // Wrap + contention: src2 frame, then src0/src1 continuously offering 3-beat frames.
        q_src(2, 8'h61, 2); q_exp(8'h61, 2); drive();
        after_last = 1'b0; gap = 0; gap_chk = 1'b1;
        tick();
        check_val("wrap_grant2", o_grant, 3'b100);
        q_src(0, 8'h21, 3); q_src(0, 8'h24, 3);
        q_src(1, 8'h31, 3); q_src(1, 8'h34, 3);
        q_exp(8'h21, 3); q_exp(8'h31, 3); q_exp(8'h24, 3); q_exp(8'h34, 3);
        drive();
        run_until_done(100);

        // After a src0 frame, src2 beats src0 in the wrap scan; src2 sends a single-beat frame.
        q_src(0, 8'h71, 2); q_exp(8'h71, 2); drive();
        after_last = 1'b0; gap = 0;
        tick();
        q_src(2, 8'h81, 1); q_src(0, 8'h91, 2);
        q_exp(8'h81, 1); q_exp(8'h91, 2);
        drive();
        run_until_done(60);
        gap_chk = 1'b0;

        // Backpressure on a 5-beat frame: output trdy 1,1,1,0,0,1 then steady 1.
        q_src(1, 8'hA1, 5); q_exp(8'hA1, 5);
        mtrdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        next_mtrdy(); drive();
        run_until_done(60);

        // Reset in the middle of a 4-beat frame after its second beat is accepted.
        q_src(0, 8'hB1, 4); q_exp(8'hB1, 4); drive();
        tick_until_src(0, 2, 20);
        i_reset_n = 1'b0;
        #1;
        check_val("mrst_grant", o_grant, 3'b000);
        check_val("mrst_busy", o_busy, 1'b0);
        check_val("mrst_s_trdy", s_axis_trdy, 3'b000);
        check_val("mrst_m_tvalid", m_axis_tvalid, 1'b0);
        check_val("mrst_m_tlast", m_axis_tlast, 1'b0);
        check_val("mrst_m_tdata", m_axis_tdata, 8'h00);
        exp_q.delete();
        for (int i = 0; i < NS; i++) sq[i].delete();
        hold_v = 1'b0; after_last = 1'b0; gap = 0;
        drive();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        q_src(1, 8'hC1, 2); q_exp(8'hC1, 2); drive();
        tick();
        check_val("post_rst_grant", o_grant, 3'b010);
        check_val("post_rst_busy", o_busy, 1'b1);
        run_until_done(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
